// File: rtl/fp_mul_seq_if.sv
// ---------------------------------------------------------------------------
// fp_mul_seq_if -- handshake bundle for the sequential floating-point multiplier
//
// Signals:
//   in_valid  / in_ready   operand handshake (producer -> multiplier)
//   fp_X, fp_Y             operands, {sign, exp[EXP_W], frac[MAN_W]}
//   r_mode                 rounding mode, sampled with the operands
//   out_valid / out_ready  result handshake (multiplier -> consumer)
//   fp_Z                   product
//   ovrf, udrf, nv         overflow / underflow / invalid, qualified by out_valid
//
// Modports: master = operand producer / result consumer, slave = multiplier.
// ---------------------------------------------------------------------------
interface fp_mul_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fp_X;
    logic [W-1:0] fp_Y;
    logic [2:0]   r_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fp_Z;
    logic         ovrf;
    logic         udrf;
    logic         nv;

    modport master (
        output in_valid, fp_X, fp_Y, r_mode, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf, nv
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, r_mode, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf, nv
    );
endinterface

// File: rtl/fp_mul_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_seq -- sequential IEEE-754-style multiplier
//
// A radix-4 Booth loop forms the exact significand product over
// N = ceil((MAN_W+2)/2) cycles, one cycle normalises and rounds, and the
// result is held until the consumer takes it. Special operands (zero,
// subnormal, infinity, NaN) bypass the loop and complete in one cycle.
// Subnormal inputs are flushed to zero and no subnormal result is produced.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    fp_mul_seq_if.slave (operand/result handshakes, flags)
// ---------------------------------------------------------------------------
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_seq_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;          // significand width incl. hidden bit
    localparam int PW = 2 * M;              // exact product width
    localparam int N  = (MAN_W + 3) / 2;    // Booth digits = ceil((MAN_W+2)/2)
    localparam int BW = 2 * N + 1;          // multiplier bits plus the y[-1] slot
    localparam int CW = $clog2(N + 1);
    localparam int EW = EXP_W + 2;          // signed exponent arithmetic width

    localparam logic [EW-1:0]    BIAS_E    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EXP_MAX_E = EW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(N - 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [MAN_W-1:0] FRAC_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] FRAC_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;

    logic              sign_r;
    logic [EXP_W-1:0]  exp_x_r;
    logic [EXP_W-1:0]  exp_y_r;
    logic [2:0]        mode_r;
    logic [PW-1:0]     mcand_r;
    logic [BW-1:0]     mplier_r;
    logic [PW-1:0]     acc_r;
    logic [CW-1:0]     cnt_r;

    logic [W-1:0]      fp_z_r;
    logic              ovrf_r;
    logic              udrf_r;
    logic              nv_r;
    logic              in_ready_r;
    logic              out_valid_r;

    // operand classification
    logic [EXP_W-1:0]  x_exp_s, y_exp_s;
    logic [MAN_W-1:0]  x_frac_s, y_frac_s;
    logic              x_zero_s, y_zero_s, x_inf_s, y_inf_s, x_nan_s, y_nan_s;
    logic              in_sign_s, special_s, accept_s;
    logic [W-1:0]      spec_z_s;
    logic              spec_nv_s;

    // Booth step
    logic [PW-1:0]     pp_mag_s;
    logic              pp_neg_s;
    logic [PW-1:0]     acc_nx_s;

    // normalise / round
    logic              norm_s;
    logic [PW-2:0]     pn_s;
    logic [MAN_W-1:0]  frac_s;
    logic              guard_s, sticky_s, lsb_s, inc_s, carry_s;
    logic [MAN_W:0]    frac_inc_s;
    logic [EW-1:0]     exp_sum_s;
    logic              ovf_s, udf_s, ovf_inf_s;
    logic [W-1:0]      rnd_z_s;

    assign x_exp_s   = bus.fp_X[W-2 -: EXP_W];
    assign y_exp_s   = bus.fp_Y[W-2 -: EXP_W];
    assign x_frac_s  = bus.fp_X[MAN_W-1:0];
    assign y_frac_s  = bus.fp_Y[MAN_W-1:0];
    assign x_zero_s  = (x_exp_s == EXP_ZERO);
    assign y_zero_s  = (y_exp_s == EXP_ZERO);
    assign x_inf_s   = (x_exp_s == EXP_ONES) && (x_frac_s == FRAC_ZERO);
    assign y_inf_s   = (y_exp_s == EXP_ONES) && (y_frac_s == FRAC_ZERO);
    assign x_nan_s   = (x_exp_s == EXP_ONES) && (x_frac_s != FRAC_ZERO);
    assign y_nan_s   = (y_exp_s == EXP_ONES) && (y_frac_s != FRAC_ZERO);
    assign in_sign_s = bus.fp_X[W-1] ^ bus.fp_Y[W-1];
    assign special_s = x_zero_s | y_zero_s | x_inf_s | y_inf_s | x_nan_s | y_nan_s;
    assign accept_s  = bus.in_valid && (state_r == IDLE);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.fp_Z      = fp_z_r;
    assign bus.ovrf      = ovrf_r;
    assign bus.udrf      = udrf_r;
    assign bus.nv        = nv_r;

    // Special-operand result; NaN inputs win over zero x infinity.
    always_comb begin
        spec_z_s  = {W{1'b0}};
        spec_nv_s = 1'b0;
        if (x_nan_s || y_nan_s) begin
            spec_z_s  = {1'b0, EXP_ONES, FRAC_QNAN};
            spec_nv_s = 1'b0;
        end else if ((x_zero_s && y_inf_s) || (x_inf_s && y_zero_s)) begin
            spec_z_s  = {1'b0, EXP_ONES, FRAC_QNAN};
            spec_nv_s = 1'b1;
        end else if (x_inf_s || y_inf_s) begin
            spec_z_s  = {in_sign_s, EXP_ONES, FRAC_ZERO};
        end else begin
            spec_z_s  = {in_sign_s, EXP_ZERO, FRAC_ZERO};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx_s = special_s ? DONE : CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ROUND;
                end else begin
                    state_nx_s = CALC;
                end
            end
            ROUND: state_nx_s = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Booth digit from {y[2i+1], y[2i], y[2i-1]}; products are exact modulo 2^PW,
    // which is enough because the final unsigned product always fits in PW bits.
    always_comb begin
        pp_mag_s = {PW{1'b0}};
        pp_neg_s = 1'b0;
        case (mplier_r[2:0])
            3'b001, 3'b010: pp_mag_s = mcand_r;
            3'b011:         pp_mag_s = {mcand_r[PW-2:0], 1'b0};
            3'b100: begin
                pp_mag_s = {mcand_r[PW-2:0], 1'b0};
                pp_neg_s = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag_s = mcand_r;
                pp_neg_s = 1'b1;
            end
            default: begin
                pp_mag_s = {PW{1'b0}};
                pp_neg_s = 1'b0;
            end
        endcase
        acc_nx_s = pp_neg_s ? (acc_r - pp_mag_s) : (acc_r + pp_mag_s);
    end

    // Operand capture and the iterative Booth accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            exp_x_r  <= EXP_ZERO;
            exp_y_r  <= EXP_ZERO;
            mode_r   <= 3'b000;
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {BW{1'b0}};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            sign_r   <= in_sign_s;
            exp_x_r  <= x_exp_s;
            exp_y_r  <= y_exp_s;
            mode_r   <= bus.r_mode;
            mcand_r  <= {{(PW-M){1'b0}}, 1'b1, x_frac_s};
            // zero-extended so the top digit is never negative
            mplier_r <= {{(BW-M-1){1'b0}}, 1'b1, y_frac_s, 1'b0};
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == CALC) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[PW-3:0], 2'b00};
            mplier_r <= {2'b00, mplier_r[BW-1:2]};
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            cnt_r    <= cnt_r;
        end
    end

    // Normalise the product to 1.f form, pick guard/sticky and the round increment.
    always_comb begin
        norm_s   = acc_r[PW-1];
        pn_s     = norm_s ? acc_r[PW-2:0] : {acc_r[PW-3:0], 1'b0};
        frac_s   = pn_s[PW-2 -: MAN_W];
        lsb_s    = pn_s[M];
        guard_s  = pn_s[M-1];
        sticky_s = |pn_s[M-2:0];
        case (mode_r)
            3'b001:  inc_s = 1'b0;
            3'b010:  inc_s = sign_r & (guard_s | sticky_s);
            3'b011:  inc_s = ~sign_r & (guard_s | sticky_s);
            3'b100:  inc_s = guard_s;
            default: inc_s = guard_s & (sticky_s | lsb_s);
        endcase
        frac_inc_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, inc_s};
        carry_s    = frac_inc_s[MAN_W];
        exp_sum_s  = {2'b00, exp_x_r} + {2'b00, exp_y_r} - BIAS_E
                   + {{(EW-1){1'b0}}, norm_s} + {{(EW-1){1'b0}}, carry_s};
        ovf_s      = !exp_sum_s[EW-1] && (exp_sum_s >= EXP_MAX_E);
        udf_s      = exp_sum_s[EW-1] || (exp_sum_s == {EW{1'b0}});
    end

    // Overflow saturates to infinity only when the mode rounds away from zero.
    always_comb begin
        case (mode_r)
            3'b001:  ovf_inf_s = 1'b0;
            3'b010:  ovf_inf_s = sign_r;
            3'b011:  ovf_inf_s = ~sign_r;
            default: ovf_inf_s = 1'b1;
        endcase
        if (ovf_s) begin
            rnd_z_s = ovf_inf_s ? {sign_r, EXP_ONES, FRAC_ZERO}
                                : {sign_r, EXP_MAXF, FRAC_ONES};
        end else if (udf_s) begin
            rnd_z_s = {sign_r, EXP_ZERO, FRAC_ZERO};
        end else begin
            // on a carry-out the low fraction bits are already zero
            rnd_z_s = {sign_r, exp_sum_s[EXP_W-1:0], frac_inc_s[MAN_W-1:0]};
        end
    end

    // Result/flag registers and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fp_z_r      <= {W{1'b0}};
            ovrf_r      <= 1'b0;
            udrf_r      <= 1'b0;
            nv_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            if (accept_s && special_s) begin
                fp_z_r <= spec_z_s;
                ovrf_r <= 1'b0;
                udrf_r <= 1'b0;
                nv_r   <= spec_nv_s;
            end else if (state_r == ROUND) begin
                fp_z_r <= rnd_z_s;
                ovrf_r <= ovf_s;
                udrf_r <= udf_s & ~ovf_s;
                nv_r   <= 1'b0;
            end else begin
                fp_z_r <= fp_z_r;
                ovrf_r <= ovrf_r;
                udrf_r <= udrf_r;
                nv_r   <= nv_r;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_seq -- directed-vector bench for fp_mul_seq (single precision)
//
// Each vector carries hand-computed product, flags and latency. Inputs are
// driven 1 ns after the rising edge, outputs sampled at the same point.
// ---------------------------------------------------------------------------
module tb_fp_mul_seq;
    logic clk;
    logic rst_n;

    int checks_cnt;
    int errors_cnt;

    fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  mode;
        logic [31:0] z;
        logic        ovrf;
        logic        udrf;
        logic        nv;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [0:22];

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, check result, optionally stall the consumer for hold cycles.
    task automatic run_op(input int idx, input vec_t v, input int hold);
        int lat;
        logic [31:0] z0;
        bus.fp_X     = v.x;
        bus.fp_Y     = v.y;
        bus.r_mode   = v.mode;
        bus.in_valid = 1'b1;
        check($sformatf("v%0d in_ready", idx), {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        // disturb the inputs: the in-flight result must not depend on them
        bus.in_valid = 1'b0;
        bus.fp_X     = ~v.x;
        bus.fp_Y     = v.y ^ 32'h00F0_0F0F;
        bus.r_mode   = ~v.mode;
        lat = 1;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), {56'd0, v.lat});
        check($sformatf("v%0d fp_Z", idx), {32'd0, bus.fp_Z}, {32'd0, v.z});
        check($sformatf("v%0d flags", idx), {61'd0, bus.ovrf, bus.udrf, bus.nv},
              {61'd0, v.ovrf, v.udrf, v.nv});
        z0 = v.z;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check($sformatf("v%0d hold%0d z", idx, h), {32'd0, bus.fp_Z}, {32'd0, z0});
            check($sformatf("v%0d hold%0d flags", idx, h), {61'd0, bus.ovrf, bus.udrf, bus.nv},
                  {61'd0, v.ovrf, v.udrf, v.nv});
            check($sformatf("v%0d hold%0d hs", idx, h), {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d after hs", idx), {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    // Safety net against a hung simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic seen;
        checks_cnt = 0;
        errors_cnt = 0;

        //        x             y             mode    z             ov    ud    nv    lat
        vecs[0]  = '{32'h40400000, 32'h40400000, 3'b001, 32'h41100000, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[1]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'b000, 32'h407FFFFE, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[2]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'b011, 32'h407FFFFF, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 3'b001, 32'h407FFFFE, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[4]  = '{32'h00000000, 32'hFF800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[5]  = '{32'h002DF854, 32'h40490FDB, 3'b000, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{32'h7F7FFFFF, 32'h40000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 8'd15};
        vecs[7]  = '{32'h7F7FFFFF, 32'h40000000, 3'b001, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 8'd15};
        vecs[8]  = '{32'h00800000, 32'h00800000, 3'b000, 32'h00000000, 1'b0, 1'b1, 1'b0, 8'd15};
        vecs[9]  = '{32'hC0400000, 32'h40400000, 3'b000, 32'hC1100000, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[10] = '{32'hFF7FFFFF, 32'h40000000, 3'b010, 32'hFF800000, 1'b1, 1'b0, 1'b0, 8'd15};
        vecs[11] = '{32'hFF7FFFFF, 32'h40000000, 3'b011, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b0, 8'd15};
        vecs[12] = '{32'h7F7FFFFF, 32'h40000000, 3'b011, 32'h7F800000, 1'b1, 1'b0, 1'b0, 8'd15};
        vecs[13] = '{32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{32'hFF800001, 32'h3F800000, 3'b000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{32'h3F800000, 32'h3F800000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'd15};
        // (1 + 3*2^-23) * 1.5: exact tie (G=1, S=0) with even LSB
        vecs[16] = '{32'h3F800003, 32'h3FC00000, 3'b000, 32'h3FC00004, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[17] = '{32'h3F800003, 32'h3FC00000, 3'b100, 32'h3FC00005, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[18] = '{32'h3F800003, 32'h3FC00000, 3'b111, 32'h3FC00004, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[19] = '{32'hBF800003, 32'h3FC00000, 3'b010, 32'hBFC00005, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[20] = '{32'h00800000, 32'h3F800000, 3'b000, 32'h00800000, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[21] = '{32'h80000000, 32'h3F800000, 3'b000, 32'h80000000, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[22] = '{32'h7F800000, 32'h7F800000, 3'b000, 32'h7F800000, 1'b0, 1'b0, 1'b0, 8'd1};

        // reset with in_valid asserted: operands must be ignored
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.fp_X      = 32'h40400000;
        bus.fp_Y      = 32'h40400000;
        bus.r_mode    = 3'b000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hs", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        check("reset fp_Z", {32'd0, bus.fp_Z}, 64'd0);
        check("reset flags", {61'd0, bus.ovrf, bus.udrf, bus.nv}, 64'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post reset idle", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

        for (int i = 0; i <= 22; i++) begin
            run_op(i, vecs[i], 0);
        end

        // consumer stall for 5 cycles in DONE
        run_op(100, vecs[0], 5);

        // reset in the sixth CALC cycle discards the operation
        bus.fp_X     = 32'h40400000;
        bus.fp_Y     = 32'h40400000;
        bus.r_mode   = 3'b000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid calc busy", {62'd0, bus.out_valid, bus.in_ready}, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid reset hs", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        check("mid reset fp_Z", {32'd0, bus.fp_Z}, 64'd0);
        check("mid reset flags", {61'd0, bus.ovrf, bus.udrf, bus.nv}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        check("no result after reset", {63'd0, seen}, 64'd0);

        // recovery after the aborted operation
        run_op(101, vecs[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (2..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 in_valid  in  1  operands and mode presented.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 fp_X  in  W  operand X, IEEE-754-style {sign, exp, frac}.
REQ-008 fp_Y  in  W  operand Y.
REQ-009 r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 fp_Z  out  W  product.
REQ-013 ovrf  out  1  overflow flag, qualified by out_valid.
REQ-014 udrf  out  1  underflow flag, qualified by out_valid.
REQ-015 nv  out  1  invalid-operation flag, qualified by out_valid.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, ROUND, DONE; in_ready=1 only in IDLE.
REQ-017 Accept on in_valid && in_ready: register fp_X, fp_Y, r_mode; IDLE->CALC, or IDLE->DONE for special operands (REQ-022..024).
REQ-018 CALC SHALL run an iterative radix-4 Booth multiply of the two (MAN_W+1)-bit significands (hidden bit 1), N = ceil((MAN_W+2)/2) cycles (13 for defaults), 2(MAN_W+1)-bit exact product, then ->ROUND.
REQ-019 ROUND (1 cycle): normalise (shift left 1 if product MSB=0), form guard bit and sticky = OR of all lower bits, round per r_mode, compute exponent, ->DONE.
REQ-020 Rounding: RNE increment if G && (S || LSB); RTZ never; RDN increment iff sign=1 && (G||S); RUP increment iff sign=0 && (G||S); RMM increment iff G. r_mode 101..111 SHALL behave as RNE.
REQ-021 Rounding carry-out of the fraction SHALL increment the exponent and clear the fraction; exponent = eX + eY - bias + norm_shift + round_carry, bias = 2^(EXP_W-1)-1, computed in EXP_W+2 signed bits.
REQ-022 Subnormal inputs (exp=0) SHALL be treated as zero; zero x finite -> signed zero {sX^sY, 0}, no flags.
REQ-023 NaN input, or zero/subnormal x infinity -> canonical quiet NaN {0, all-ones exp, frac MSB=1, rest 0}; nv=1 only for the zero x infinity case.
REQ-024 Infinity x finite nonzero or infinity x infinity -> signed infinity, no flags.
REQ-025 Biased exponent >= all-ones after rounding -> ovrf=1; result = signed infinity for RNE/RMM, RDN with sign=1, RUP with sign=0; otherwise signed max finite.
REQ-026 Biased exponent <= 0 -> udrf=1, result signed zero (no subnormal outputs).
REQ-027 Result sign always sX^sY, including zero and infinity results.
REQ-028 DONE: out_valid=1, fp_Z/flags held stable until out_valid && out_ready, then ->IDLE; the next operand SHALL NOT be accepted in the same cycle.
REQ-029 Latency from accept edge to out_valid: N+2 cycles for the normal path (15 default), 1 cycle for the special path.
REQ-030 Changes on fp_X/fp_Y/r_mode after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, fp_Z=0, ovrf=udrf=nv=0, regardless of state, including mid-CALC; the in-flight operation is discarded.
REQ-032 in_valid during the reset cycle SHALL be ignored.

Verification
REQ-033 fp_X=0x40400000, fp_Y=0x40400000, r_mode=001 -> fp_Z=0x41100000, no flags, out_valid 15 cycles after accept.
REQ-034 fp_X=0x3FFFFFFF, fp_Y=0x3FFFFFFF: RNE -> 0x407FFFFE, RUP -> 0x407FFFFF, RTZ -> 0x407FFFFE; confirms sticky/guard handling.
REQ-035 fp_X=0x00000000, fp_Y=0xFF800000 -> fp_Z=0x7FC00000, nv=1 after 1 cycle; fp_X=0x002DF854 x 0x40490FDB -> 0x00000000, no flags.
REQ-036 fp_X=0x7F7FFFFF, fp_Y=0x40000000: RNE -> 0x7F800000 ovrf=1; RTZ -> 0x7F7FFFFF ovrf=1; fp_X=0x00800000 x 0x00800000 -> 0x00000000 udrf=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> fp_Z/flags stable, in_ready=0; assert rst_n=0 in CALC cycle 6 -> next cycle IDLE, out_valid=0, no result ever emitted.
